// File: rtl/alu_pkg.sv
// Shared constants for the ALU board interface: op codes, LED byte
// selectors and the reader state encoding.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    localparam logic [2:0] LED_SEL_BYTE0 = 3'd0;
    localparam logic [2:0] LED_SEL_BYTE1 = 3'd1;
    localparam logic [2:0] LED_SEL_BYTE2 = 3'd2;
    localparam logic [2:0] LED_SEL_BYTE3 = 3'd3;
    localparam logic [2:0] LED_SEL_FLAGS = 3'd4;
    localparam int unsigned NUM_LED_SEL  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Hold-counter width: max(1, clog2(settle+1)).
    function automatic int unsigned cnt_width(input int unsigned settle);
        return (settle == 0) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/led_settle_timer.sv
// Hold counter for one selector value. Counts up to SETTLE_CYCLES and
// stops there; o_expired marks the last cycle of the hold window.
module led_settle_timer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == LAST);

    // Count while enabled until the hold window ends; clear restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_led_reader.sv
// Reader end of the ALU board interface: steps c_led_sw through the five
// LED bytes, samples led at the end of each hold window and presents the
// reassembled result/flags with a one-cycle done pulse.
module alu_led_reader
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  alu_op_in,
    input  logic [2:0]  ab_sel_in,
    output logic [2:0]  alu_op,
    output logic [2:0]  ab_sw,
    output logic [2:0]  c_led_sw,
    input  logic [7:0]  led,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [7:0]  flags
);

    localparam logic [2:0] LAST_SLOT = 3'(NUM_LED_SEL - 1);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [31:0] r_shadow;
    logic        w_expired;
    logic        w_clear;
    logic        w_enable;

    assign w_enable = (r_state == ST_READ);
    assign w_clear  = ((r_state == ST_IDLE) && start) ||
                      ((r_state == ST_READ) && w_expired);

    led_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_expired (w_expired)
    );

    // Read sequencer: latch request, walk selectors, capture, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
            alu_op   <= '0;
            ab_sw    <= '0;
            c_led_sw <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        alu_op   <= alu_op_in;
                        ab_sw    <= ab_sel_in;
                        c_led_sw <= LED_SEL_BYTE0;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_expired) begin
                        if (r_idx == LAST_SLOT) begin
                            // Flags byte is taken straight from led so the
                            // whole word is published on this single edge.
                            result  <= r_shadow;
                            flags   <= led;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_shadow[{r_idx[1:0], 3'b000} +: 8] <= led;
                            r_idx    <= r_idx + 3'd1;
                            c_led_sw <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_led_reader.md
Name: alu_led_reader

Overview:
- Reader end of the ALU board interface. The ALU shows its 32-bit result and its flags 8 bits at a time on `led[7:0]`, with the byte chosen by `c_led_sw`.
- This block drives `alu_op`, `ab_sw` and `c_led_sw` on behalf of a host. It steps `c_led_sw` through all five selector values, waits a settle time on each, samples `led`, and reassembles `result[31:0]` and `flags[7:0]`.
- Sits between a host controller (start/done handshake) and ALU_module. It replaces manual switch sequencing.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each selector value is held before `led` is sampled (0 allowed; each value is held SETTLE_CYCLES+1 cycles).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a read; honoured only while not busy
- alu_op_in  in  3  operation code to apply (0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt, 7 sll)
- ab_sel_in  in  3  operand-pair select to apply
- alu_op  out  3  to ALU_module.alu_op
- ab_sw  out  3  to ALU_module.ab_sw
- c_led_sw  out  3  to ALU_module.c_led_sw; 0..3 select result bytes 0..3 (LSB first), 4 selects the flags byte
- led  in  8  from ALU_module.led
- busy  out  1  read in progress
- done  out  1  one-cycle pulse: result/flags just updated
- result  out  32  reassembled result, held until the next done
- flags  out  8  flags byte (captured at c_led_sw=4), held until the next done

Behaviour:
- Reset (async assert, sync-released use): state IDLE. `alu_op`, `ab_sw`, `c_led_sw`, `result`, `flags` = 0; `busy` = `done` = 0; counters = 0.
- States: IDLE, READ. There is no separate done state.
- IDLE: at edge E0 with `start`=1:
  - latch `alu_op<=alu_op_in`, `ab_sw<=ab_sel_in`, `c_led_sw<=0`;
  - set `idx<=0`, `cnt<=0`, `busy<=1`;
  - go to READ.
- READ, at each edge:
  - If `cnt != SETTLE_CYCLES`: `cnt++`.
  - Else capture `led` into shadow slot `idx` (bytes 0..3 into `result` bits [8*idx+7:8*idx], slot 4 into `flags`).
    - If `idx < 4`: `idx++`, `c_led_sw<=idx+1`, `cnt<=0`.
    - If `idx == 4`: copy the shadow registers to `result`/`flags` atomically, pulse `done<=1`, `busy<=0`, go to IDLE.
- Timing:
  - `led` is sampled only at the last edge of each hold window; changes earlier in the window are ignored.
  - The final capture is at edge E0+5*(SETTLE_CYCLES+1).
  - `done` is high for exactly the following cycle.
- Outputs never change mid-read except `c_led_sw`:
  - `alu_op` and `ab_sw` stay stable for the whole read and stay held after done.
  - `c_led_sw` stays at 4 after done until the next start.
  - `c_led_sw` values 5..7 are never driven.
- `start` while busy is ignored. It is not queued, and `alu_op_in`/`ab_sel_in` are not resampled.
- `start` in the `done` cycle (state is already IDLE) is accepted: back-to-back reads with no gap.
- `result`/`flags` never show a partial read; they change only on the done edge.
- Reset mid-read: immediate return to IDLE with all outputs 0. The partial capture is discarded and no `done` is issued.
- Counter width is max(1, clog2(SETTLE_CYCLES+1)). `idx` is 3 bits.

Decomposition:
- Shared package alu_pkg:
  - operation-code constants OP_AND..OP_SLL (0..7);
  - LED_SEL_BYTE0..LED_SEL_BYTE3 (0..3), LED_SEL_FLAGS (4), NUM_LED_SEL (5);
  - state encoding IDLE/READ.
- One natural sub-module, led_settle_timer: a parameterised hold counter with clear input and `expired` output. The FSM and capture logic stay in the top module.

Test Plan:
- ALU model drives `led` = byte `c_led_sw` of 32'hDEADBEEF and 8'h5A for selector 4. SETTLE_CYCLES=2, start with op=4, ab=3. Required:
  - `c_led_sw` sequence 0,0,0,1,1,1,2,2,2,3,3,3,4,4,4;
  - `done` one cycle after edge E0+15;
  - `result`=32'hDEADBEEF, `flags`=8'h5A;
  - `alu_op`=4 and `ab_sw`=3 throughout.
- Assert `start` again at E0+5 with op=7 -> ignored: same `done` time, `alu_op` stays 4.
- Model glitches `led` to 8'hFF on the first two cycles of each hold window -> `result` is still 32'hDEADBEEF (only the last cycle is sampled).
- Deassert `rst_n` at E0+7 -> all outputs 0 immediately, no `done`. After release, a new start with 32'h01234567/8'h03 gives exactly those values.
- Start held high through the `done` cycle -> second read begins at that edge, `busy` is low only during the done cycle. SETTLE_CYCLES=0 build -> `done` after edge E0+5, `c_led_sw` 0,1,2,3,4.
